qr_binarizer: RTL and testbench

Pipelined AXI4-Stream stage that converts RGB888 camera video to a 1-bit-per-pixel binarized stream for QR decoding. It sits directly upstream of the frame capture stage. Bit 0 of its output feeds the BRAM write data; its TUSER[0] output drives that stage's start-of-frame input. The threshold is either manual or adaptive: the mean luma of the previous complete frame plus a signed offset.

---
 rtl/qr_binarizer.sv | 151 +++++++++++++++
 tb/tb_qr_binarizer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qr_binarizer.sv
// qr_binarizer
// Three-stage AXI4-Stream pipeline that turns RGB888 video into a 1-bit
// "dark pixel" stream for QR decoding. The threshold is either a manual
// value or the mean luma of the previous complete frame plus a signed offset.
//
// Ports:
//   s00_axis_aclk, s00_axis_areset   clock, synchronous active-high reset
//   s00_axis_*                       RGB pixel input ({R,G,B} in tdata[23:0]),
//                                    tuser = start of frame, tlast = end of line
//   m00_axis_*                       binarized output, tdata[0] = 1 for dark,
//                                    tuser/tlast travel with their pixel
//   cfg_manual_en, cfg_threshold     manual threshold select and value
//   cfg_offset                       signed offset applied to the adaptive mean
//   cur_threshold                    threshold applied to the pixel now in S3
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high. Once m00_axis_tvalid is high, the m00 outputs hold until
// m00_axis_tready is seen high. All stages advance on one enable,
// ce = m00_axis_tready | ~m00_axis_tvalid, which is also s00_axis_tready.
module qr_binarizer #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int LOG2_PIXELS            = 16,
    parameter int DEFAULT_THRESHOLD      = 128
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_areset,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tlast,
    input  logic                              s00_axis_tuser,
    output logic                              m00_axis_tvalid,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                              m00_axis_tlast,
    output logic                              m00_axis_tuser,
    input  logic                              cfg_manual_en,
    input  logic [7:0]                        cfg_threshold,
    input  logic [7:0]                        cfg_offset,
    output logic [7:0]                        cur_threshold
);

    localparam logic [LOG2_PIXELS:0] CNT_FULL = {1'b1, {LOG2_PIXELS{1'b0}}};

    // Upper input bits carry no pixel information.
    logic unused_tdata_hi;
    assign unused_tdata_hi = ^s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:24];

    logic ce;
    assign ce              = m00_axis_tready | ~m00_axis_tvalid;
    assign s00_axis_tready = ce;

    // S1: weighted colour products
    logic        s1_valid, s1_user, s1_last;
    logic [15:0] s1_pr, s1_pg, s1_pb;

    // S2: luma
    logic        s2_valid, s2_user, s2_last;
    logic [7:0]  s2_y;
    logic [15:0] luma_sum;
    assign luma_sum = s1_pr + s1_pg + s1_pb;

    // Frame statistics
    logic [LOG2_PIXELS+7:0] acc;
    logic [LOG2_PIXELS:0]   cnt;
    logic [7:0]             adapt_thr;

    logic [7:0]        frame_mean;
    logic signed [9:0] thr_adj;
    logic [7:0]        thr_clamped;
    logic              frame_done;
    logic [7:0]        thr_next;
    logic [7:0]        thr_use;

    assign frame_mean = acc[LOG2_PIXELS+7:LOG2_PIXELS];
    assign thr_adj    = $signed({2'b00, frame_mean}) + $signed({{2{cfg_offset[7]}}, cfg_offset});

    always_comb begin
        thr_clamped = thr_adj[7:0];
        if (thr_adj < 10'sd0) begin
            thr_clamped = 8'd0;
        end else if (thr_adj > 10'sd255) begin
            thr_clamped = 8'd255;
        end
    end

    // A start-of-frame beat closing a complete frame compares against the
    // freshly computed threshold, so every pixel of a frame sees one value.
    assign frame_done = s2_valid & s2_user & (cnt == CNT_FULL);
    assign thr_next   = frame_done ? thr_clamped : adapt_thr;
    assign thr_use    = cfg_manual_en ? cfg_threshold : thr_next;

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            s1_valid        <= 1'b0;
            s1_user         <= 1'b0;
            s1_last         <= 1'b0;
            s1_pr           <= '0;
            s1_pg           <= '0;
            s1_pb           <= '0;
            s2_valid        <= 1'b0;
            s2_user         <= 1'b0;
            s2_last         <= 1'b0;
            s2_y            <= '0;
            m00_axis_tvalid <= 1'b0;
            m00_axis_tdata  <= '0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tuser  <= 1'b0;
            cur_threshold   <= 8'(DEFAULT_THRESHOLD);
            acc             <= '0;
            cnt             <= '0;
            adapt_thr       <= 8'(DEFAULT_THRESHOLD);
        end else if (ce) begin
            s1_valid <= s00_axis_tvalid;
            s1_user  <= s00_axis_tuser;
            s1_last  <= s00_axis_tlast;
            s1_pr    <= 16'(s00_axis_tdata[23:16]) * 16'd77;
            s1_pg    <= 16'(s00_axis_tdata[15:8])  * 16'd150;
            s1_pb    <= 16'(s00_axis_tdata[7:0])   * 16'd29;

            s2_valid <= s1_valid;
            s2_user  <= s1_user;
            s2_last  <= s1_last;
            s2_y     <= luma_sum[15:8];

            m00_axis_tvalid   <= s2_valid;
            m00_axis_tlast    <= s2_last;
            m00_axis_tuser    <= s2_user;
            m00_axis_tdata    <= '0;
            m00_axis_tdata[0] <= s2_valid & (s2_y < thr_use);
            cur_threshold     <= thr_use;

            if (s2_valid) begin
                if (s2_user) begin
                    if (frame_done) begin
                        adapt_thr <= thr_clamped;
                    end
                    acc <= (LOG2_PIXELS+8)'(s2_y);
                    cnt <= (LOG2_PIXELS+1)'(1);
                end else begin
                    acc <= acc + (LOG2_PIXELS+8)'(s2_y);
                    if (cnt != CNT_FULL) begin
                        cnt <= cnt + (LOG2_PIXELS+1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_qr_binarizer.sv
// Testbench for qr_binarizer (LOG2_PIXELS = 4, 16-pixel frames).
// A negedge monitor keeps a frame-level reference model and an expected queue
// of {tuser, tlast, dark} per accepted pixel; scenario tasks add targeted checks.
module tb_qr_binarizer;

    localparam int L    = 4;
    localparam int FULL = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] s_tdata = '0;
    logic        s_tlast = 1'b0;
    logic        s_tuser = 1'b0;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tuser;
    logic        cfg_manual_en = 1'b0;
    logic [7:0]  cfg_threshold = 8'd0;
    logic [7:0]  cfg_offset = 8'd0;
    logic [7:0]  cur_threshold;

    always #5 clk = ~clk;

    qr_binarizer #(
        .C_S00_AXIS_TDATA_WIDTH(32),
        .C_M00_AXIS_TDATA_WIDTH(32),
        .LOG2_PIXELS(L),
        .DEFAULT_THRESHOLD(128)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid),
        .s00_axis_tready(s_tready),
        .s00_axis_tdata(s_tdata),
        .s00_axis_tlast(s_tlast),
        .s00_axis_tuser(s_tuser),
        .m00_axis_tvalid(m_tvalid),
        .m00_axis_tready(m_tready),
        .m00_axis_tdata(m_tdata),
        .m00_axis_tlast(m_tlast),
        .m00_axis_tuser(m_tuser),
        .cfg_manual_en(cfg_manual_en),
        .cfg_threshold(cfg_threshold),
        .cfg_offset(cfg_offset),
        .cur_threshold(cur_threshold)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- scoreboard / reference model ----------------
    logic [2:0]  exp_q[$];
    int          msum = 0;
    int          mcnt = 0;
    int          mthr = 128;
    int          n_out = 0;
    logic        last_bit = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] sv_data;
    logic        sv_last, sv_user;

    always @(negedge clk) begin
        logic [2:0] e;
        int r, g, b, y, off, t, thr;
        if (rst) begin
            exp_q.delete();
            msum = 0;
            mcnt = 0;
            mthr = 128;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== {1'b1, sv_data, sv_last, sv_user}) begin
                    bad++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b u=%b, want v=1 d=%h l=%b u=%b",
                             m_tvalid, m_tdata, m_tlast, m_tuser, sv_data, sv_last, sv_user);
                end
            end
            if (m_tvalid && m_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: got d=%h with empty expected queue", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_tuser, m_tlast, m_tdata} !== {e[2], e[1], 31'b0, e[0]}) begin
                        bad++;
                        $display("FAIL pixel_out: got u=%b l=%b d=%h, want u=%b l=%b d=%h",
                                 m_tuser, m_tlast, m_tdata, e[2], e[1], {31'b0, e[0]});
                    end
                end
                last_bit = m_tdata[0];
                n_out++;
            end
            stall_prev = m_tvalid && !m_tready;
            sv_data = m_tdata;
            sv_last = m_tlast;
            sv_user = m_tuser;
            if (s_tvalid && s_tready) begin
                r = int'(s_tdata[23:16]);
                g = int'(s_tdata[15:8]);
                b = int'(s_tdata[7:0]);
                y = (77 * r + 150 * g + 29 * b) / 256;
                if (s_tuser) begin
                    if (mcnt == FULL) begin
                        off = cfg_offset[7] ? int'(cfg_offset) - 256 : int'(cfg_offset);
                        t = msum / FULL + off;
                        if (t < 0) t = 0;
                        if (t > 255) t = 255;
                        mthr = t;
                    end
                    msum = y;
                    mcnt = 1;
                end else begin
                    msum = (msum + y) % (FULL * 256);
                    if (mcnt < FULL) mcnt++;
                end
                thr = cfg_manual_en ? int'(cfg_threshold) : mthr;
                exp_q.push_back({s_tuser, s_tlast, (y < thr) ? 1'b1 : 1'b0});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [23:0] rgb, input logic u, input logic l);
        logic accepted = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = {8'hA5, rgb};
        s_tuser  = u;
        s_tlast  = l;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (s_tready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        total++;
        if (!accepted) begin
            bad++;
            $display("FAIL send_timeout: got no acceptance in 200 cycles, want acceptance");
        end
    endtask

    task automatic send_frame(input logic [23:0] rgb, input int n);
        for (int i = 0; i < n; i++) send(rgb, i == 0, (i % 4) == 3);
    endtask

    task automatic drain();
        int guard = 0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
        end
    endtask

    task automatic check_thr(input string name, input logic [7:0] want_thr, input logic want_bit);
        @(negedge clk);
        total++;
        if (cur_threshold !== want_thr) begin
            bad++;
            $display("FAIL %s_thr: got %0d, want %0d", name, cur_threshold, want_thr);
        end
        total++;
        if (last_bit !== want_bit) begin
            bad++;
            $display("FAIL %s_bit: got %b, want %b", name, last_bit, want_bit);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== 35'b0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b d=%h l=%b u=%b, want all 0", m_tvalid, m_tdata, m_tlast, m_tuser);
        end
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL reset_tready: got %b, want 1", s_tready);
        end
        total++;
        if (cur_threshold !== 8'd128) begin
            bad++;
            $display("FAIL reset_thr: got %0d, want 128", cur_threshold);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [23:0] pix[4];
        logic [3:0]  dark, usr, lst;
        pix[0] = 24'hFFFFFF; pix[1] = 24'h000000; pix[2] = 24'h808080; pix[3] = 24'h7F7F7F;
        dark = 4'b1010;  // bit i for pixel i
        usr  = 4'b0001;
        lst  = 4'b1000;
        m_tready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                s_tvalid = 1'b1;
                s_tdata  = {8'h00, pix[c]};
                s_tuser  = usr[c];
                s_tlast  = lst[c];
            end else begin
                s_tvalid = 1'b0;
            end
            @(negedge clk);
            if (c >= 3 && c < 7) begin
                total++;
                if ({m_tvalid, m_tuser, m_tlast, m_tdata} !== {1'b1, usr[c-3], lst[c-3], 31'b0, dark[c-3]}) begin
                    bad++;
                    $display("FAIL basic_pix%0d: got v=%b u=%b l=%b d=%h, want v=1 u=%b l=%b d=%h",
                             c - 3, m_tvalid, m_tuser, m_tlast, m_tdata, usr[c-3], lst[c-3], {31'b0, dark[c-3]});
                end
            end else begin
                total++;
                if (m_tvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL basic_latency_c%0d: got tvalid=%b, want 0", c, m_tvalid);
                end
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int  n0 = n_out;
        bit  done = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    send($urandom() & 24'hFFFFFF, i == 0, (i % 8) == 7);
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                int guard = 0;
                while (!done && guard < 5000) begin
                    m_tready = ($urandom_range(0, 1) == 1);
                    @(posedge clk);
                    #1;
                    guard++;
                end
            end
        join
        drain();
        total++;
        if (n_out - n0 != 64) begin
            bad++;
            $display("FAIL backpressure_count: got %0d outputs, want 64", n_out - n0);
        end
    endtask

    task automatic test_adaptive();
        do_reset();
        cfg_manual_en = 1'b0;
        cfg_offset = 8'd0;
        send_frame(24'h404040, 16);
        drain();
        check_thr("adapt_f1", 8'd128, 1'b1);
        send_frame(24'h505050, 16);
        drain();
        check_thr("adapt_f2", 8'd64, 1'b0);
    endtask

    task automatic test_clamp();
        cfg_offset = 8'd20;
        send_frame(24'hFFFFFF, 16);
        drain();
        send_frame(24'h000000, 16);
        drain();
        check_thr("clamp_hi", 8'd255, 1'b1);
        cfg_offset = 8'hEC;  // -20
        send_frame(24'h000000, 16);
        drain();
        check_thr("clamp_lo", 8'd0, 1'b0);
    endtask

    task automatic test_short_manual();
        do_reset();
        cfg_offset = 8'd0;
        send_frame(24'h404040, 16);
        send_frame(24'h505050, 10);
        send_frame(24'h3C3C3C, 16);
        drain();
        check_thr("short_hold", 8'd64, 1'b1);
        cfg_manual_en = 1'b1;
        cfg_threshold = 8'd200;
        send_frame(24'hC0C0C0, 4);
        drain();
        check_thr("manual", 8'd200, 1'b1);
        cfg_manual_en = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        cfg_offset = 8'd0;
        m_tready = 1'b1;
        send_frame(24'h404040, 16);
        send(24'h505050, 1'b1, 1'b0);
        send(24'h505050, 1'b0, 1'b0);
        send(24'h505050, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_tvalid: got %b, want 0", m_tvalid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        send_frame(24'h646464, 16);
        drain();
        check_thr("midreset_default", 8'd128, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_adaptive();
        test_clamp();
        test_short_manual();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
